// File: rtl/fifo_gen.sv
// fifo_gen: parametrised synchronous FIFO with occupancy count, thresholds, sticky errors and optional FWFT read
module fifo_gen #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_ok, push_ok;
  assign pop_ok = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CW'(AF_LEVEL);
  assign almost_empty = count <= CW'(AE_LEVEL);
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
      overflow <= (overflow && !clr_err) || (push && !push_ok);
      underflow <= (underflow && !clr_err) || (pop && !pop_ok);
    end
  // FWFT shows the head word directly; standard mode latches it on an accepted pop
  if (FWFT != 0) begin : g_fwft
    assign data_out = mem[rd_ptr];
  end else begin : g_reg
    always_ff @(posedge clk or negedge reset)
      if (!reset) data_out <= '0;
      else if (pop_ok) data_out <= mem[rd_ptr];
  end
endmodule
